day_counter: RTL and testbench

DAY_COUNTER -- requirements
Module: day_counter

---
 rtl/day_counter.sv | 207 ++++++++++++++++++++
 tb/tb_day_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/day_counter.sv
// Day-of-year counter (1..99) with BCD digits, two debounced push-buttons
// and an optional auto-advance prescaler.
//
// Build option:
//   DAY_COUNTER_DEBOUNCE_EN  when defined, each synchronized key level must
//                            hold for DB_CYCLES consecutive clocks before the
//                            key FSM sees it. When undefined, the synchronized
//                            level feeds the FSM directly and no debounce
//                            counters exist.
//
// Key index 0 is the increment key, index 1 is the decrement key.
module day_counter #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_key_n,
  input  logic       dec_key_n,
  input  logic       run,
  output logic [6:0] number,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       changed
);

  localparam int unsigned NUM_W = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned NKEYS = 2;
  localparam int unsigned KEY_INC = 0;
  localparam int unsigned KEY_DEC = 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [NUM_W-1:0] NUM_MIN  = NUM_W'(1);
  localparam logic [NUM_W-1:0] NUM_MAX  = NUM_W'(99);
  localparam logic [NUM_W-1:0] NUM_TEN  = NUM_W'(10);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Reject parameter values that would make the counters meaningless
  if (TICK_DIV == 0) begin : g_bad_tick_div
    $error("day_counter: TICK_DIV must be at least 1");
  end
  if (DB_CYCLES == 0) begin : g_bad_db_cycles
    $error("day_counter: DB_CYCLES must be at least 1");
  end

  typedef enum logic {
    KEY_RELEASED = 1'b0,
    KEY_PRESSED  = 1'b1
  } key_state_e;

  logic [NKEYS-1:0] key_raw_n;
  logic [NKEYS-1:0] sync1_q;
  logic [NKEYS-1:0] sync2_q;
  logic [NKEYS-1:0] level_c;
  logic [NKEYS-1:0] step_c;
  key_state_e       key_q [NKEYS];

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [NUM_W-1:0] number_q;
  logic [NUM_W-1:0] number_d;
  logic [DIG_W-1:0] tens_q;
  logic [DIG_W-1:0] tens_d;
  logic [DIG_W-1:0] ones_q;
  logic [DIG_W-1:0] ones_d;
  logic             changed_q;
  logic             changed_d;

  logic             inc_c;
  logic             dec_c;
  logic             both_c;
  logic             tick_c;
  logic [NUM_W-1:0] num_up_c;
  logic [NUM_W-1:0] num_dn_c;

  assign key_raw_n = {dec_key_n, inc_key_n};

  // Two-flop synchronizers; reset parks them at the released (high) level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw_n;
      sync2_q <= sync1_q;
    end
  end

`ifdef DAY_COUNTER_DEBOUNCE_EN
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0]  db_cnt_q [NKEYS];
  logic [NKEYS-1:0] filt_q;

  // Filtered level follows the synchronized level only after it has
  // disagreed for DB_CYCLES consecutive clocks; agreeing again restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '1;
      for (int k = 0; k < NKEYS; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        if (sync2_q[k] == filt_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          filt_q[k]   <= sync2_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  assign level_c = filt_q;
`else
  assign level_c = sync2_q;
`endif

  // Per-key press FSM: a step is taken only on the released-to-pressed move
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NKEYS; k++) begin
        key_q[k] <= KEY_RELEASED;
      end
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        case (key_q[k])
          KEY_RELEASED: if (!level_c[k]) key_q[k] <= KEY_PRESSED;
          KEY_PRESSED:  if (level_c[k])  key_q[k] <= KEY_RELEASED;
          default:                       key_q[k] <= KEY_RELEASED;
        endcase
      end
    end
  end

  // Step decode kept combinational so a press lands on the third edge
  always_comb begin
    step_c = '0;
    for (int k = 0; k < NKEYS; k++) begin
      step_c[k] = (key_q[k] == KEY_RELEASED) && !level_c[k];
    end
  end

  // Wrapped neighbours of the current value; out-of-range values recover
  always_comb begin
    num_up_c = (number_q >= NUM_MAX) ? NUM_MIN : number_q + NUM_W'(1);
    num_dn_c = (number_q <= NUM_MIN) ? NUM_MAX : number_q - NUM_W'(1);
  end

  // Arbitration between key steps and the auto tick, plus digit split
  always_comb begin
    inc_c     = step_c[KEY_INC] & ~step_c[KEY_DEC];
    dec_c     = step_c[KEY_DEC] & ~step_c[KEY_INC];
    both_c    = step_c[KEY_INC] &  step_c[KEY_DEC];
    tick_c    = run && (pre_q == PRE_LAST);
    pre_d     = '0;
    number_d  = number_q;

    if (!run) begin
      pre_d = '0;
    end else if (inc_c || dec_c || tick_c) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    if (inc_c) begin
      number_d = num_up_c;
    end else if (dec_c) begin
      number_d = num_dn_c;
    end else if (tick_c && !both_c) begin
      number_d = num_up_c;
    end

    changed_d = (number_d != number_q);
    tens_d    = DIG_W'(number_d / NUM_TEN);
    ones_d    = DIG_W'(number_d % NUM_TEN);
  end

  // Output and prescaler registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      number_q  <= NUM_MIN;
      tens_q    <= '0;
      ones_q    <= DIG_W'(1);
      changed_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      number_q  <= number_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      changed_q <= changed_d;
    end
  end

  assign number  = number_q;
  assign tens    = tens_q;
  assign ones    = ones_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_day_counter.sv
// Testbench for day_counter: directed scenarios plus randomized key/run/reset
// traffic compared every cycle against a history-based reference model.
module tb_day_counter;

  localparam int unsigned TD   = 4;
  localparam int unsigned DB   = 8;
  localparam int          HMAX = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic       inc_key_n;
  logic       dec_key_n;
  logic       run;
  logic [6:0] number;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       changed;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_num;
  int m_pre;
  int n;
  bit m_chg;
  bit m_held [2];
  bit m_filt [2];
  bit hist   [2][HMAX];

  day_counter #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .inc_key_n (inc_key_n),
    .dec_key_n (dec_key_n),
    .run       (run),
    .number    (number),
    .tens      (tens),
    .ones      (ones),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Key level after the two synchronizer stages at edge j since reset release
  function automatic bit sync_lvl(input int k, input int j);
    if (j < 2) return 1'b1;
    return hist[k][j-2];
  endfunction

  function automatic int wrap_up(input int v);
    return (v % 99) + 1;
  endfunction

  function automatic int wrap_dn(input int v);
    return ((v + 97) % 99) + 1;
  endfunction

  task automatic model_edge(input bit r, input bit ikn, input bit dkn, input bit rn);
    bit lvl [2];
    bit st  [2];
    bit raw [2];
    bit all_diff;
    raw[0] = ikn;
    raw[1] = dkn;
    if (r) begin
      m_num = 1; m_pre = 0; m_chg = 0; n = 0;
      m_held[0] = 0; m_held[1] = 0;
      m_filt[0] = 1; m_filt[1] = 1;
      return;
    end
    for (int k = 0; k < 2; k++) begin
`ifdef DAY_COUNTER_DEBOUNCE_EN
      lvl[k] = m_filt[k];
`else
      lvl[k] = sync_lvl(k, n);
`endif
      st[k]     = !lvl[k] && !m_held[k];
      m_held[k] = !lvl[k];
`ifdef DAY_COUNTER_DEBOUNCE_EN
      all_diff = 1'b1;
      for (int j = n - int'(DB) + 1; j <= n; j++) begin
        if (sync_lvl(k, j) == m_filt[k]) all_diff = 1'b0;
      end
      if (all_diff) m_filt[k] = !m_filt[k];
`else
      all_diff = 1'b0;
`endif
      hist[k][n] = raw[k];
    end
    n++;
    m_chg = 0;
    if (st[0] != st[1]) begin
      m_num = st[0] ? wrap_up(m_num) : wrap_dn(m_num);
      m_pre = 0;
      m_chg = 1;
    end else if (st[0] && st[1]) begin
      m_pre = rn ? (m_pre + 1) % int'(TD) : 0;
    end else if (!rn) begin
      m_pre = 0;
    end else if (m_pre == int'(TD) - 1) begin
      m_num = wrap_up(m_num);
      m_pre = 0;
      m_chg = 1;
    end else begin
      m_pre++;
    end
  endtask

  task automatic cyc(input bit r, input bit ikn, input bit dkn, input bit rn);
    reset     = r;
    inc_key_n = ikn;
    dec_key_n = dkn;
    run       = rn;
    @(posedge clk);
    model_edge(r, ikn, dkn, rn);
    #1;
    chk("model_number",  32'(number),  32'(m_num));
    chk("model_tens",    32'(tens),    32'(m_num / 10));
    chk("model_ones",    32'(ones),    32'(m_num % 10));
    chk("model_changed", 32'(changed), 32'(m_chg));
  endtask

  task automatic press(input bit is_inc, input bit is_dec, input int hold, input int rel);
    repeat (hold) cyc(1'b0, !is_inc, !is_dec, 1'b0);
    repeat (rel)  cyc(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    bit ikn;
    bit dkn;
    bit rn;
    bit r;
    bit lo;

    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_number",  32'(number),  32'd1);
    chk("rst_tens",    32'(tens),    32'd0);
    chk("rst_ones",    32'(ones),    32'd1);
    chk("rst_changed", 32'(changed), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);

`ifndef DAY_COUNTER_DEBOUNCE_EN
    // Single inc press lands on the third edge after first low sample
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("inc_edge1", 32'(number), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("inc_edge2", 32'(number), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("inc_edge3_num",  32'(number),  32'd2);
    chk("inc_edge3_ones", 32'(ones),    32'd2);
    chk("inc_edge3_chg",  32'(changed), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); chk("inc_pulse_end", 32'(changed), 32'd0);
    press(1'b1, 1'b0, 4, 4);
    chk("inc_hold_once", 32'(number), 32'd2);

    // Decrement wrap 1 -> 99, then increment wrap 99 -> 1
    press(1'b0, 1'b1, 6, 4);
    chk("dec_to_1", 32'(number), 32'd1);
    press(1'b0, 1'b1, 6, 4);
    chk("dec_wrap_num",  32'(number), 32'd99);
    chk("dec_wrap_tens", 32'(tens),   32'd9);
    chk("dec_wrap_ones", 32'(ones),   32'd9);
    press(1'b1, 1'b0, 6, 4);
    chk("inc_wrap_num", 32'(number), 32'd1);

    repeat (4) press(1'b1, 1'b0, 4, 4);
    chk("at_5", 32'(number), 32'd5);

    // Auto-advance: 20 run cycles = 5 ticks, then partial count discarded
    repeat (20) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("run20_num", 32'(number), 32'd10);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("run_resume_wait", 32'(number), 32'd10);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("run_resume_step", 32'(number), 32'd11);

    repeat (116) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("at_40", 32'(number), 32'd40);

    // Simultaneous inc and dec: no change, no pulse
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("both_changed", 32'(changed), 32'd0);
    end
    press(1'b0, 1'b0, 0, 4);
    chk("both_num", 32'(number), 32'd40);

    repeat (68) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("at_57", 32'(number), 32'd57);

    // Reset while inc is held, key still held after release
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_held_num", 32'(number), 32'd1);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("held_after_rst_wait", 32'(number), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("held_after_rst_step", 32'(number), 32'd2);
    repeat (10) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("held_no_more", 32'(number), 32'd2);
    press(1'b0, 1'b0, 0, 4);
    press(1'b1, 1'b0, 5, 4);
    chk("repress", 32'(number), 32'd3);
`else
    // Bouncing key: low 3, high 2, low 10 -> one step after 8 stable lows
    for (int i = 1; i <= 35; i++) begin
      lo = (i <= 3) || (i >= 6 && i <= 15);
      cyc(1'b0, !lo, 1'b1, 1'b0);
      if (i == 15) chk("db_before_step", 32'(number), 32'd1);
      if (i == 16) begin
        chk("db_step_num", 32'(number),  32'd2);
        chk("db_step_chg", 32'(changed), 32'd1);
      end
    end
    chk("db_single_step", 32'(number), 32'd2);
`endif

    // Randomized traffic against the model
    ikn = 1'b1; dkn = 1'b1; rn = 1'b0; r = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(9, 0) == 0) ikn = ~ikn;
      if ($urandom_range(9, 0) == 0) dkn = ~dkn;
      if ($urandom_range(39, 0) == 0) begin
        ikn = 1'b0;
        dkn = 1'b0;
      end
      if ($urandom_range(24, 0) == 0) rn = ~rn;
      r = ($urandom_range(199, 0) == 0);
      cyc(r, ikn, dkn, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
